tick_period_meter: RTL and testbench
====================================

// Module: tick_period_meter
// PURPOSE
//  Receive end of the clock-divider tick: takes a 1-cycle strobe train (divider output or
//  any external pulse), measures clk cycles between rising edges, flags in/out of tolerance
//  against an expected period, asserts lock after a run of good periods, and flags loss of
//  ticks. Sits beside the divider for self-check, or on external timebase inputs.
// PARAMETERS
//  CNT_W     31      width of period counter and period_out
//  EXPECT    250001  expected period in clk cycles (divider terminal count + 1)
//  TOL       2       allowed |period - EXPECT| for in_tol
//  TIMEOUT   500002  cycles without an edge before loss is declared; must be < 2^CNT_W
//  LOCK_CNT  4       consecutive in-tolerance periods required for locked (>=1)
//  SYNC_EN   1       1: 2-flop synchronizer on tick_in; 0: tick_in is already clk-synchronous
// PORTS
//  clk           in   1      clock
//  reset         in   1      reset, asynchronous, active-high
//  tick_in       in   1      strobe to measure; rising edge counts
//  clear         in   1      synchronous soft reset, same effect as reset
//  period_out    out  CNT_W  last measured period, held until next measurement
//  period_valid  out  1      1-cycle pulse when period_out updates
//  in_tol        out  1      tolerance result for period_out, updates with period_valid
//  locked        out  1      LOCK_CNT consecutive in-tolerance periods seen
//  timeout       out  1      sticky loss-of-tick flag
// BEHAVIOUR
//  - Reset/clear: all outputs 0, cnt=0, streak=0, state IDLE. clear beats any same-cycle edge.
//  - Edge detect: rising edge on the synchronized signal (SYNC_EN=1: +2 cycles latency;
//    SYNC_EN=0: 0 cycles), registered into edge (+1). A held-high tick_in counts once.
//  - FSM states IDLE, MEAS, LOST:
//    IDLE: wait for first edge -> MEAS, cnt<=1; no period_valid (no reference edge yet).
//    MEAS: cnt increments each cycle. On edge: period_out<=cnt, period_valid=1 next cycle,
//          cnt<=1. If cnt==TIMEOUT and no edge: -> LOST, timeout<=1, locked<=0, streak<=0.
//    LOST: cnt holds. On edge: -> MEAS, cnt<=1, timeout<=0, no period_valid.
//  - Counter never wraps: TIMEOUT caps it. Edge in the cycle cnt==TIMEOUT wins: period
//    TIMEOUT is reported, state stays MEAS.
//  - A divider pulsing every P cycles gives period_out==P (edge-to-edge distance).
//  - in_tol registered with period_out: (period>=EXPECT-TOL)&&(period<=EXPECT+TOL); compare
//    at CNT_W+1 bits, lower bound clamps at 0.
//  - Lock: each valid period with in_tol increments streak (saturates at LOCK_CNT); at
//    LOCK_CNT, locked<=1 in the same cycle as period_valid. An out-of-tol period zeroes
//    streak and clears locked on that cycle.
//  - Reset mid-measurement discards the partial count. The first edge after reset only arms.
// STRUCTURE
//  - tick_meter_pkg: FSM state encoding (IDLE/MEAS/LOST), default constants
//    (EXPECT, TIMEOUT) tied to the divider terminal count.
//  - Sub-module sync_edge_det: optional 2-flop sync plus rising-edge pulse; reusable for
//    buttons and external strobes. Top holds FSM, counter, compare, and lock logic.
// TESTING  (bench params: EXPECT=10 TOL=1 TIMEOUT=20 LOCK_CNT=3 SYNC_EN=0)
//  1 Ticks every 10 cycles x5 -> first edge arms; then period_valid x4 with period_out=10,
//    in_tol=1; locked rises on the 3rd valid period.
//  2 Locked, then one 13-cycle gap -> period_out=13, in_tol=0, locked=0 same cycle,
//    streak restarts; 3 more 10-cycle periods -> relock.
//  3 Stop ticks after lock -> timeout=1 and locked=0 exactly 20 cycles after last edge;
//    next edge clears timeout, no period_valid; following edge 10 later -> period_out=10.
//  4 Edge exactly at cnt==20 -> period_out=20, in_tol=0, timeout stays 0.
//  5 Assert reset async mid-period, and clear coincident with an edge -> all outputs 0,
//    IDLE, no period_valid; tick_in held high 50 cycles counts one edge only.
//  6 SYNC_EN=1 with tick_in driven off-clock -> periods still 10, output 3 cycles after edge.

Source files
------------

// File: rtl/tick_meter_pkg.sv
// Shared state encoding and default timing constants for the tick period meter.
// Defaults follow the clock divider's terminal count so the meter can self-check it.
package tick_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_LOST = 2'd2
    } meter_state_e;

    localparam int unsigned DIV_TERMINAL = 32'd250000;
    localparam int unsigned DEF_CNT_W    = 32'd31;
    localparam int unsigned DEF_EXPECT   = DIV_TERMINAL + 32'd1;
    localparam int unsigned DEF_TOL      = 32'd2;
    // Two missing periods before loss is declared.
    localparam int unsigned DEF_TIMEOUT  = 32'd2 * DEF_EXPECT;
    localparam int unsigned DEF_LOCK_CNT = 32'd4;

endpackage

// File: rtl/sync_edge_det.sv
// Optional 2-flop synchronizer followed by a registered rising-edge pulse.
// Usable for tick strobes, buttons and other external single-bit inputs.
module sync_edge_det #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic sig_in,
    output logic pulse
);

    logic sig;
    logic prev;

    generate
        if (SYNC_EN) begin : g_sync
            logic [1:0] sync_q;

            // Two-flop synchronizer for inputs not related to clk.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_q <= 2'b00;
                end else begin
                    sync_q <= {sync_q[0], sig_in};
                end
            end

            assign sig = sync_q[1];
        end else begin : g_direct
            assign sig = sig_in;
        end
    endgenerate

    // Rising-edge pulse; clear reloads the history so a held level is not seen again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else if (clear) begin
            prev  <= sig;
            pulse <= 1'b0;
        end else begin
            prev  <= sig;
            pulse <= sig & ~prev;
        end
    end

endmodule

// File: rtl/tick_period_meter.sv
// Measures clk cycles between rising edges of a strobe, checks them against an
// expected period, tracks lock over consecutive good periods and flags tick loss.
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned EXPECT   = DEF_EXPECT,
    parameter int unsigned TOL      = DEF_TOL,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
    parameter bit          SYNC_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             in_tol,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned SW = (LOCK_CNT > 32'd1) ? $clog2(LOCK_CNT + 32'd1) : 32'd1;

    // Tolerance window evaluated one bit wider than the counter; lower bound clamps at 0.
    localparam logic [63:0] LO64 = (64'(EXPECT) >= 64'(TOL)) ? (64'(EXPECT) - 64'(TOL)) : 64'd0;
    localparam logic [63:0] HI64 = 64'(EXPECT) + 64'(TOL);
    localparam logic [CNT_W:0] LO_B = LO64[CNT_W:0];
    localparam logic [CNT_W:0] HI_B = HI64[CNT_W:0];

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [SW-1:0]    LOCK_C    = SW'(LOCK_CNT);
    localparam logic [SW-1:0]    LOCK_M1   = SW'(LOCK_CNT - 32'd1);
    localparam logic [SW-1:0]    STREAK_1  = SW'(1);

    meter_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic [SW-1:0]    streak;
    logic             tick_edge;
    logic             cnt_in_tol;

    sync_edge_det #(
        .SYNC_EN (SYNC_EN)
    ) u_edge (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .sig_in (tick_in),
        .pulse  (tick_edge)
    );

    assign cnt_in_tol = ({1'b0, cnt} >= LO_B) && ({1'b0, cnt} <= HI_B);

    // Measurement FSM with counter, tolerance result, lock streak and loss flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            streak       <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            in_tol       <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else if (clear) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            streak       <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            in_tol       <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick_edge) begin
                        state <= ST_MEAS;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= cnt;
                    end
                end
                ST_MEAS: begin
                    // An edge in the cnt==TIMEOUT cycle still reports a period.
                    if (tick_edge) begin
                        period_out   <= cnt;
                        period_valid <= 1'b1;
                        in_tol       <= cnt_in_tol;
                        cnt          <= CNT_ONE;
                        if (cnt_in_tol) begin
                            if (streak < LOCK_C) begin
                                streak <= streak + STREAK_1;
                            end else begin
                                streak <= streak;
                            end
                            if (streak >= LOCK_M1) begin
                                locked <= 1'b1;
                            end else begin
                                locked <= locked;
                            end
                        end else begin
                            streak <= '0;
                            locked <= 1'b0;
                        end
                    end else if (cnt == TIMEOUT_C) begin
                        state   <= ST_LOST;
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        streak  <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_LOST: begin
                    if (tick_edge) begin
                        state   <= ST_MEAS;
                        cnt     <= CNT_ONE;
                        timeout <= 1'b0;
                    end else begin
                        cnt <= cnt;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// Randomized and directed bench for tick_period_meter against a timestamp-based
// reference model of edge-to-edge distances, tolerance, lock and loss.
module tb_tick_period_meter;

    localparam int CNT_W    = 16;
    localparam int EXPECT   = 10;
    localparam int TOL      = 1;
    localparam int TIMEOUT  = 20;
    localparam int LOCK_CNT = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick_in;
    logic             clear;
    logic             tick_in2;
    logic [CNT_W-1:0] period_out, period_out2;
    logic             period_valid, in_tol, locked, timeout;
    logic             period_valid2, in_tol2, locked2, timeout2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tick_period_meter #(
        .CNT_W(CNT_W), .EXPECT(EXPECT), .TOL(TOL), .TIMEOUT(TIMEOUT),
        .LOCK_CNT(LOCK_CNT), .SYNC_EN(1'b0)
    ) u_dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .clear(clear),
        .period_out(period_out), .period_valid(period_valid), .in_tol(in_tol),
        .locked(locked), .timeout(timeout)
    );

    tick_period_meter #(
        .CNT_W(CNT_W), .EXPECT(EXPECT), .TOL(TOL), .TIMEOUT(TIMEOUT),
        .LOCK_CNT(LOCK_CNT), .SYNC_EN(1'b1)
    ) u_dut_sync (
        .clk(clk), .reset(reset), .tick_in(tick_in2), .clear(1'b0),
        .period_out(period_out2), .period_valid(period_valid2), .in_tol(in_tol2),
        .locked(locked2), .timeout(timeout2)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 measuring, 2 lost; periods from timestamps.
    int   m_mode, m_t, m_last, m_streak;
    logic m_prev, m_pend;
    int   e_period;
    logic e_valid, e_intol, e_locked, e_timeout;

    task automatic model_reset();
        m_mode = 0; m_last = 0; m_streak = 0;
        m_prev = 1'b0; m_pend = 1'b0;
        e_period = 0; e_valid = 1'b0; e_intol = 1'b0; e_locked = 1'b0; e_timeout = 1'b0;
    endtask

    task automatic model_step(input logic tk, input logic clr);
        logic edge_now;
        int   el;
        m_t++;
        e_valid = 1'b0;
        if (clr) begin
            model_reset();
            m_prev = tk;
        end else begin
            edge_now = m_pend;
            m_pend   = tk & ~m_prev;
            m_prev   = tk;
            el       = m_t - m_last;
            if (edge_now) begin
                if (m_mode == 1) begin
                    e_period = el;
                    e_valid  = 1'b1;
                    e_intol  = (el >= EXPECT - TOL) && (el <= EXPECT + TOL);
                    if (e_intol) begin
                        if (m_streak < LOCK_CNT) m_streak++;
                        e_locked = (m_streak == LOCK_CNT);
                    end else begin
                        m_streak = 0;
                        e_locked = 1'b0;
                    end
                end else if (m_mode == 2) begin
                    e_timeout = 1'b0;
                end
                m_mode = 1;
                m_last = m_t;
            end else if (m_mode == 1 && el == TIMEOUT) begin
                m_mode    = 2;
                e_timeout = 1'b1;
                e_locked  = 1'b0;
                m_streak  = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_valid"},   64'(period_valid), 64'(e_valid));
        check_val({tag, "_period"},  64'(period_out),   64'(e_period));
        check_val({tag, "_in_tol"},  64'(in_tol),       64'(e_intol));
        check_val({tag, "_locked"},  64'(locked),       64'(e_locked));
        check_val({tag, "_timeout"}, 64'(timeout),      64'(e_timeout));
    endtask

    // One clock: drive at negedge, model at posedge, compare at the next negedge.
    task automatic step(input logic tk, input logic clr, input string tag);
        tick_in = tk;
        clear   = clr;
        @(posedge clk);
        model_step(tk, clr);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic pulse(input int width, input int gap, input string tag);
        for (int i = 0; i < gap; i++) step((i < width) ? 1'b1 : 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1 check_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int gap, width, sel;
    int nvalid2;

    initial begin
        reset = 1'b0; tick_in = 1'b0; clear = 1'b0; tick_in2 = 1'b0;
        m_t = 0;
        model_reset();
        do_reset();

        // 1: steady 10-cycle ticks, lock on the third valid period
        for (int k = 0; k < 5; k++) pulse(1, 10, "t1");
        step(1'b0, 1'b0, "t1");
        check_val("t1_locked_const", 64'(locked), 64'd1);
        check_val("t1_period_const", 64'(period_out), 64'd10);

        // 2: one 13-cycle gap breaks lock, three good periods relock
        pulse(1, 13, "t2");
        for (int k = 0; k < 4; k++) pulse(1, 10, "t2");
        check_val("t2_relocked", 64'(locked), 64'd1);

        // 3: stop ticks until loss, then recover
        step(1'b1, 1'b0, "t3");
        for (int k = 0; k < 25; k++) step(1'b0, 1'b0, "t3");
        check_val("t3_timeout_const", 64'(timeout), 64'd1);
        pulse(1, 10, "t3");
        pulse(1, 10, "t3");
        pulse(1, 10, "t3");

        // 4: edge exactly at the timeout count
        pulse(1, 20, "t4");
        pulse(1, 10, "t4");
        check_val("t4_timeout_low", 64'(timeout), 64'd0);

        // 5: async reset mid-period, clear against edges, held-high input
        pulse(1, 5, "t5");
        do_reset();
        pulse(1, 10, "t5");
        step(1'b1, 1'b1, "t5c");
        step(1'b0, 1'b0, "t5");
        step(1'b1, 1'b0, "t5");
        step(1'b0, 1'b1, "t5c");
        for (int k = 0; k < 50; k++) step(1'b1, 1'b0, "t5h");
        pulse(0, 9, "t5");
        pulse(1, 10, "t5");
        step(1'b0, 1'b0, "t5");

        // Randomized gaps, widths and occasional clears
        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 19);
            if (sel < 12)      gap = $urandom_range(8, 12);
            else if (sel < 16) gap = $urandom_range(17, 24);
            else if (sel < 18) gap = $urandom_range(2, 7);
            else               gap = $urandom_range(25, 40);
            width = (sel == 5) ? $urandom_range(1, gap - 1) : 1;
            if ($urandom_range(0, 29) == 0) step($urandom_range(0, 1) == 1, 1'b1, "rndc");
            pulse(width, gap, "rnd");
        end

        // 6: synchronized instance with an off-clock strobe
        do_reset();
        tick_in = 1'b0;
        nvalid2 = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #2 tick_in2 = 1'b1;
            @(posedge clk);
            #2 tick_in2 = 1'b0;
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk);
                check_val("t6_valid", 64'(period_valid2), 64'((k > 0) && (c == 4)));
                check_val("t6_locked", 64'(locked2), 64'((k == 3) && (c >= 4)));
                if (period_valid2) begin
                    nvalid2++;
                    check_val("t6_period", 64'(period_out2), 64'd10);
                    check_val("t6_in_tol", 64'(in_tol2), 64'd1);
                end
            end
        end
        check_val("t6_count", 64'(nvalid2), 64'd3);
        check_val("t6_timeout", 64'(timeout2), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
